// File: rtl/accu_32bit_stream.sv
// Streaming group accumulator: sums N_OPS operands from a valid/ready stream
// through a 32-bit carry-lookahead adder and emits one sum + sticky carry beat.

module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign sum  = p ^ c[3:0];
  assign cout = c[4];
endmodule

module adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        c32
);
  logic [8:0] c;

  assign c[0] = cin;

  // Lookahead inside each nibble, group carries rippled between nibbles.
  for (genvar i = 0; i < 8; i++) begin : g_nib
    cla_4bit u_cla (
      .a   (a[4*i +: 4]),
      .b   (b[4*i +: 4]),
      .cin (c[i]),
      .sum (sum[4*i +: 4]),
      .cout(c[i+1])
    );
  end

  assign c32 = c[8];
endmodule

module accu_32bit_stream #(
  parameter int N_OPS = 4,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        ready_in,
  output logic [31:0] data_out,
  output logic        carry_out,
  output logic        valid_out,
  input  logic        ready_out
);
  localparam logic [0:0] ACC = 1'b0;
  localparam logic [0:0] OUT = 1'b1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_OPS - 1);

  logic [0:0]       state;
  logic [31:0]      acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic [31:0]      sum;
  logic             c32;
  logic             in_hs;
  logic             out_hs;

  adder_32bit u_add (
    .a  (acc),
    .b  (data_in),
    .cin(1'b0),
    .sum(sum),
    .c32(c32)
  );

  // NOTE: gating with rst_n keeps the upstream from seeing a handshake
  // during a reset cycle, since the registered state only clears at the edge.
  assign ready_in = (state == ACC) & rst_n;
  assign in_hs    = valid_in & ready_in;
  assign out_hs   = valid_out & ready_out;

  // NOTE: all registers use non-blocking assignments so every branch reads
  // pre-edge values (acc, ovf) regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      data_out  <= '0;
      carry_out <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (in_hs) begin
            if (cnt == LAST) begin
              data_out  <= sum;
              carry_out <= ovf | c32;
              valid_out <= 1'b1;
              state     <= OUT;
              acc       <= '0;
              cnt       <= '0;
              ovf       <= 1'b0;
            end else begin
              acc <= sum;
              ovf <= ovf | c32;
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          if (out_hs) begin
            valid_out <= 1'b0;
            state     <= ACC;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_accu_32bit_stream.sv
// Directed bench: a 4-operand instance for grouping, carry, backpressure,
// gaps and reset, plus a 1-operand instance for single-beat groups.

module tb_accu_32bit_stream;
  logic        clk = 1'b0;
  logic        rst_n;

  logic [31:0] d4;
  logic        v4;
  logic        ri4;
  logic [31:0] do4;
  logic        co4;
  logic        vo4;
  logic        ro4;

  logic [31:0] d1;
  logic        v1;
  logic        ri1;
  logic [31:0] do1;
  logic        co1;
  logic        vo1;
  logic        ro1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  accu_32bit_stream #(.N_OPS(4), .CNT_W(8)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (d4),
    .valid_in (v4),
    .ready_in (ri4),
    .data_out (do4),
    .carry_out(co4),
    .valid_out(vo4),
    .ready_out(ro4)
  );

  accu_32bit_stream #(.N_OPS(1), .CNT_W(8)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (d1),
    .valid_in (v1),
    .ready_in (ri1),
    .data_out (do1),
    .carry_out(co1),
    .valid_out(vo1),
    .ready_out(ro1)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed4(input logic [31:0] op);
    d4 = op;
    v4 = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    d4 = '0; v4 = 1'b0; ro4 = 1'b0;
    d1 = '0; v1 = 1'b0; ro1 = 1'b0;
    step();
    step();
    checks++;
    if (ri4 !== 1'b0) begin
      errors++; $display("FAIL reset_ready_in: got %b expected 0", ri4);
    end
    checks++;
    if ({vo4, co4, do4} !== {1'b0, 1'b0, 32'h0}) begin
      errors++; $display("FAIL reset_outputs: got v=%b c=%b d=%h expected v=0 c=0 d=00000000", vo4, co4, do4);
    end
    checks++;
    if ({ri1, vo1, co1, do1} !== {1'b0, 1'b0, 1'b0, 32'h0}) begin
      errors++; $display("FAIL reset_n1: got r=%b v=%b c=%b d=%h expected all zero", ri1, vo1, co1, do1);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (ri4 !== 1'b1) begin
      errors++; $display("FAIL post_reset_ready_in: got %b expected 1", ri4);
    end
  endtask

  task automatic test_basic_group();
    ro4 = 1'b1;
    feed4(32'd1);
    feed4(32'd2);
    feed4(32'd3);
    checks++;
    if (vo4 !== 1'b0) begin
      errors++; $display("FAIL basic_early_valid: got %b expected 0", vo4);
    end
    feed4(32'd4);
    v4 = 1'b0;
    checks++;
    if ({vo4, co4, do4} !== {1'b1, 1'b0, 32'd10}) begin
      errors++; $display("FAIL basic_result: got v=%b c=%b d=%h expected v=1 c=0 d=0000000a", vo4, co4, do4);
    end
    checks++;
    if (ri4 !== 1'b0) begin
      errors++; $display("FAIL basic_ready_in_out: got %b expected 0", ri4);
    end
    step();
    checks++;
    if ({vo4, ri4} !== 2'b01) begin
      errors++; $display("FAIL basic_one_cycle: got v=%b r=%b expected v=0 r=1", vo4, ri4);
    end
  endtask

  task automatic test_carry_sticky();
    ro4 = 1'b1;
    feed4(32'hFFFF_FFFF);
    feed4(32'h0000_0001);
    feed4(32'h0);
    feed4(32'h0);
    v4 = 1'b0;
    checks++;
    if ({vo4, co4, do4} !== {1'b1, 1'b1, 32'h0}) begin
      errors++; $display("FAIL carry_wrap: got v=%b c=%b d=%h expected v=1 c=1 d=00000000", vo4, co4, do4);
    end
    step();
    for (int i = 0; i < 4; i++) feed4(32'd5);
    v4 = 1'b0;
    checks++;
    if ({vo4, co4, do4} !== {1'b1, 1'b0, 32'd20}) begin
      errors++; $display("FAIL carry_cleared: got v=%b c=%b d=%h expected v=1 c=0 d=00000014", vo4, co4, do4);
    end
    step();
  endtask

  task automatic test_backpressure();
    ro4 = 1'b0;
    feed4(32'h100);
    feed4(32'h200);
    feed4(32'h300);
    feed4(32'h400);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({vo4, co4, do4, ri4} !== {1'b1, 1'b0, 32'hA00, 1'b0}) begin
        errors++; $display("FAIL bp_hold_%0d: got v=%b c=%b d=%h r=%b expected v=1 c=0 d=00000a00 r=0", i, vo4, co4, do4, ri4);
      end
      v4 = (i % 2 == 0);
      d4 = 32'h0BAD;
      step();
    end
    v4 = 1'b0;
    ro4 = 1'b1;
    checks++;
    if ({vo4, do4} !== {1'b1, 32'hA00}) begin
      errors++; $display("FAIL bp_before_accept: got v=%b d=%h expected v=1 d=00000a00", vo4, do4);
    end
    step();
    checks++;
    if ({vo4, ri4, do4} !== {1'b0, 1'b1, 32'hA00}) begin
      errors++; $display("FAIL bp_accepted: got v=%b r=%b d=%h expected v=0 r=1 d=00000a00", vo4, ri4, do4);
    end
  endtask

  task automatic test_sparse();
    logic [31:0] ops [4];
    ops[0] = 32'h10; ops[1] = 32'h20; ops[2] = 32'h30; ops[3] = 32'h40;
    ro4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      feed4(ops[i]);
      v4 = 1'b0;
      checks++;
      if (i < 3) begin
        if (vo4 !== 1'b0) begin
          errors++; $display("FAIL sparse_early_%0d: got v=%b expected 0", i, vo4);
        end
      end else begin
        if ({vo4, co4, do4} !== {1'b1, 1'b0, 32'hA0}) begin
          errors++; $display("FAIL sparse_result: got v=%b c=%b d=%h expected v=1 c=0 d=000000a0", vo4, co4, do4);
        end
      end
      step();
      step();
    end
  endtask

  task automatic test_reset_mid_group();
    ro4 = 1'b1;
    feed4(32'd7);
    feed4(32'd9);
    v4 = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ri4 !== 1'b0) begin
      errors++; $display("FAIL midrst_ready_in: got %b expected 0", ri4);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (vo4 !== 1'b0) begin
        errors++; $display("FAIL midrst_no_beat_%0d: got v=%b expected 0", i, vo4);
      end
      step();
    end
    for (int i = 0; i < 4; i++) feed4(32'd1);
    v4 = 1'b0;
    checks++;
    if ({vo4, co4, do4} !== {1'b1, 1'b0, 32'd4}) begin
      errors++; $display("FAIL midrst_result: got v=%b c=%b d=%h expected v=1 c=0 d=00000004", vo4, co4, do4);
    end
    step();
  endtask

  task automatic test_single_op();
    ro1 = 1'b1;
    d1 = 32'hDEAD_BEEF;
    v1 = 1'b1;
    step();
    checks++;
    if ({vo1, co1, do1, ri1} !== {1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0}) begin
      errors++; $display("FAIL n1_first: got v=%b c=%b d=%h r=%b expected v=1 c=0 d=deadbeef r=0", vo1, co1, do1, ri1);
    end
    d1 = 32'd3;
    step();
    checks++;
    if ({vo1, ri1} !== 2'b01) begin
      errors++; $display("FAIL n1_gap: got v=%b r=%b expected v=0 r=1", vo1, ri1);
    end
    step();
    v1 = 1'b0;
    checks++;
    if ({vo1, co1, do1, ri1} !== {1'b1, 1'b0, 32'd3, 1'b0}) begin
      errors++; $display("FAIL n1_second: got v=%b c=%b d=%h r=%b expected v=1 c=0 d=00000003 r=0", vo1, co1, do1, ri1);
    end
    step();
    checks++;
    if ({vo1, ri1} !== 2'b01) begin
      errors++; $display("FAIL n1_done: got v=%b r=%b expected v=0 r=1", vo1, ri1);
    end
  endtask

  initial begin
    test_reset();
    test_basic_group();
    test_carry_sticky();
    test_backpressure();
    test_sparse();
    test_reset_mid_group();
    test_single_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
